serial_tx_scheduler: RTL and testbench

Shares one 8N2 serial transmitter between `NUM_REQ` byte-stream requesters. Whole packets are granted round-robin. Each packet is wrapped in a frame: start-of-frame byte, source ID, payload, then an 8-bit checksum. Bytes go to the transmitter one at a time through its start/busy handshake. The block sits between the vision-result producers and the single UART transmitter on the board.

---
 rtl/serial_tx_pkg.sv | 21 ++
 rtl/serial_tx_scheduler_rr_arbiter.sv | 30 +++
 rtl/serial_tx_scheduler.sv | 137 +++++++++++++
 tb/tb_serial_tx_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the serial frame scheduler.
// Holds the frame state enum, the issue/gap phase encoding and size limits.
package serial_tx_pkg;

  localparam int         MAX_REQ     = 8;
  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_ID,
    ST_DATA,
    ST_CSUM
  } state_t;

  typedef enum logic {
    PH_ISSUE = 1'b0,
    PH_GAP   = 1'b1
  } phase_t;

endpackage

// File: rtl/serial_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first request at or after i_ptr, wrapping.
// Zero latency; o_next_ptr is winner+1 mod NUM_REQ, or i_ptr unchanged when nothing requests.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [2:0]         i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [2:0]         o_next_ptr
);

  logic w_found;

  always_comb begin
    o_gnt      = '0;
    o_next_ptr = i_ptr;
    w_found    = 1'b0;
    // Walk candidates in priority order k = 0.. starting from the pointer.
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!w_found && i_req[j] && (j == (int'(i_ptr) + k) % NUM_REQ)) begin
          w_found    = 1'b1;
          o_gnt[j]   = 1'b1;
          o_next_ptr = 3'((j + 1) % NUM_REQ);
        end
      end
    end
  end

endmodule

// File: rtl/serial_tx_scheduler.sv
// Round-robin packet scheduler framing SOF/ID/payload/checksum onto one start/busy transmitter.
// Grant one cycle after a request; each byte waits for tx_busy low, granted requester stalls via req_ready.
module serial_tx_scheduler
  import serial_tx_pkg::*;
#(
  parameter int         NUM_REQ  = 4,
  parameter logic [7:0] SOF_BYTE = SOF_DEFAULT,
  parameter logic [7:0] ID_BASE  = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 frame_active
);

  state_t               r_state;
  phase_t               r_phase;
  logic [NUM_REQ-1:0]   r_grant;
  logic                 r_frame_active;
  logic [7:0]           r_csum;
  logic [2:0]           r_ptr;
  logic                 r_last;

  logic [NUM_REQ-1:0]   w_arb_gnt;
  logic [2:0]           w_next_ptr;
  logic                 w_gvalid;
  logic                 w_glast;
  logic [7:0]           w_gdata;
  logic [7:0]           w_id;
  logic                 w_issue;
  logic [7:0]           w_tx_data;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .i_req      (req_valid),
    .i_ptr      (r_ptr),
    .o_gnt      (w_arb_gnt),
    .o_next_ptr (w_next_ptr)
  );

  assign w_gvalid = |(req_valid & r_grant);
  assign w_glast  = |(req_last & r_grant);

  always_comb begin
    w_gdata = '0;
    w_id    = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (r_grant[j]) begin
        w_gdata = req_data[8*j +: 8];
        w_id    = ID_BASE + 8'(j);
      end
    end
  end

  // Strobe is suppressed while rst is high so an aborted frame never emits another byte.
  assign w_issue = !rst && (r_state != ST_IDLE) && (r_phase == PH_ISSUE) && !tx_busy &&
                   ((r_state != ST_DATA) || w_gvalid);

  always_comb begin
    case (r_state)
      ST_SOF:  w_tx_data = SOF_BYTE;
      ST_ID:   w_tx_data = w_id;
      ST_DATA: w_tx_data = w_gdata;
      ST_CSUM: w_tx_data = r_csum;
      default: w_tx_data = 8'h00;
    endcase
  end

  assign tx_start     = w_issue;
  assign tx_data      = w_tx_data;
  assign req_ready    = (w_issue && (r_state == ST_DATA)) ? r_grant : '0;
  assign grant        = r_grant;
  assign frame_active = r_frame_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_phase        <= PH_ISSUE;
      r_grant        <= '0;
      r_frame_active <= 1'b0;
      r_csum         <= '0;
      r_ptr          <= '0;
      r_last         <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req_valid) begin
            r_grant        <= w_arb_gnt;
            r_frame_active <= 1'b1;
            r_csum         <= '0;
            r_ptr          <= w_next_ptr;
            r_state        <= ST_SOF;
            r_phase        <= PH_ISSUE;
          end
        end
        default: begin
          if (r_phase == PH_ISSUE) begin
            if (w_issue) begin
              r_phase <= PH_GAP;
              if ((r_state == ST_ID) || (r_state == ST_DATA)) begin
                r_csum <= r_csum + w_tx_data;
              end
              if (r_state == ST_DATA) begin
                r_last <= w_glast;
              end
              if (r_state == ST_CSUM) begin
                r_frame_active <= 1'b0;
              end
            end
          end else begin
            // The gap cycle covers the transmitter's busy-rise latency before the next byte.
            r_phase <= PH_ISSUE;
            case (r_state)
              ST_SOF:  r_state <= ST_ID;
              ST_ID:   r_state <= ST_DATA;
              ST_DATA: r_state <= r_last ? ST_CSUM : ST_DATA;
              ST_CSUM: begin
                r_state <= ST_IDLE;
                r_grant <= '0;
              end
              default: r_state <= ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Bench for serial_tx_scheduler: directed scenarios plus random traffic against a frame-level model.
// Transmitter model raises busy the cycle after a start and holds it busy_len cycles.
module tb_serial_tx_scheduler;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic [N-1:0]   grant;
  logic           frame_active;

  always #5 clk = ~clk;

  serial_tx_scheduler #(
    .NUM_REQ  (N),
    .SOF_BYTE (8'hA5),
    .ID_BASE  (8'h00)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .grant        (grant),
    .frame_active (frame_active)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transmitter model
  int   busy_len   = 20;
  int   busy_cnt   = 0;
  logic force_busy = 1'b0;
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0) || force_busy;

  // Requesters: each owns a byte queue; valid while bytes remain and not held off
  logic [7:0]   q_dat [N][$];
  bit           q_lst [N][$];
  logic [N-1:0] have = '0;
  logic [N-1:0] hold = '0;
  logic [N-1:0] acc  = '0;
  assign req_valid = have & ~hold;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && q_dat[i].size() > 0) begin
        q_dat[i].delete(0);
        q_lst[i].delete(0);
      end
      have[i]            = q_dat[i].size() > 0;
      req_data[8*i +: 8] = have[i] ? q_dat[i][0] : 8'h00;
      req_last[i]        = have[i] ? q_lst[i][0] : 1'b0;
    end
  end

  // Frame-level reference model and monitor
  int         cyc         = 0;
  int         last_strobe = -10;
  int         n_strobe    = 0;
  int         mptr        = 0;
  int         rdy_cnt [N];
  logic [N-1:0] prev_gnt   = '0;
  logic [N-1:0] prev_valid = '0;
  logic       prev_fa     = 1'b0;
  logic [7:0] exp_q [$];
  logic [7:0] slog  [$];
  int         glog  [$];

  always @(negedge clk) begin
    cyc++;
    acc = req_ready;
    if (rst) begin
      exp_q.delete();
      mptr     = 0;
      prev_gnt = '0;
      prev_fa  = 1'b0;
    end else begin
      if (grant != 0 && prev_gnt == 0) begin : arb
        int w;
        logic [7:0] s;
        w = -1;
        for (int k = 0; k < N; k++) begin
          int j;
          j = (mptr + k) % N;
          if (w < 0 && prev_valid[j]) w = j;
        end
        if (w < 0) begin
          chk("grant_without_request", 32'(grant), 0);
        end else begin
          chk("grant_winner", 32'(grant), 32'(1 << w));
          chk("grant_frame_active", 32'(frame_active), 1);
          chk("sof_latency", 32'(tx_start), 32'(!tx_busy));
          s = 8'(w);
          exp_q.push_back(8'hA5);
          exp_q.push_back(s);
          for (int b = 0; b < q_dat[w].size(); b++) begin
            s = s + q_dat[w][b];
            exp_q.push_back(q_dat[w][b]);
            if (q_lst[w][b]) break;
          end
          exp_q.push_back(s);
          glog.push_back(w);
          mptr = (w + 1) % N;
        end
      end
      if (tx_start) begin
        chk("strobe_while_busy", 32'(tx_busy), 0);
        chk("strobe_spacing_ge2", 32'(cyc - last_strobe >= 2), 1);
        chk("strobe_in_frame", 32'(frame_active), 1);
        if (exp_q.size() == 0) chk("strobe_unexpected", 32'(tx_data), 32'h100);
        else chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        slog.push_back(tx_data);
        last_strobe = cyc;
        n_strobe++;
      end
      if (req_ready != 0) begin
        chk("ready_only_granted", 32'(req_ready & ~grant), 0);
        chk("ready_with_strobe", 32'(tx_start), 1);
        for (int i = 0; i < N; i++) if (req_ready[i]) rdy_cnt[i]++;
      end
      if (prev_fa && !frame_active) begin
        chk("fa_falls_after_csum", cyc - last_strobe, 1);
        chk("frame_fully_sent", exp_q.size(), 0);
      end
      prev_gnt = grant;
      prev_fa  = frame_active;
    end
    prev_valid = req_valid;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input bit l);
    q_dat[r].push_back(d);
    q_lst[r].push_back(l);
  endtask

  function automatic bit qs_empty();
    for (int i = 0; i < N; i++) if (q_dat[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (t < 20000 && !(grant == 0 && !frame_active && exp_q.size() == 0 && qs_empty())) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) chk({tag, "_idle_timeout"}, t, 0);
    step(1);
  endtask

  task automatic wait_ready(input string tag, input int r, input int n);
    int t;
    t = 0;
    while (rdy_cnt[r] < n && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_ready_seen"}, 32'(t < 2000), 1);
  endtask

  logic [7:0] e1 [5] = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
  int         e2 [5] = '{0, 1, 2, 3, 0};

  initial begin
    for (int i = 0; i < N; i++) rdy_cnt[i] = 0;

    // Reset state
    rst = 1'b1;
    step(3);
    @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_frame_active", 32'(frame_active), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    step(1);
    rst = 1'b0;

    // Requester 2: 10, 20(last)
    slog.delete();
    push_byte(2, 8'h10, 1'b0);
    push_byte(2, 8'h20, 1'b1);
    wait_idle("t1");
    chk("t1_len", slog.size(), 5);
    for (int k = 0; k < 5; k++) chk("t1_byte", 32'(slog[k]), 32'(e1[k]));
    chk("t1_ready2_pulses", rdy_cnt[2], 2);

    // All four requesters valid at once after reset: strict rotation
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    glog.delete();
    push_byte(0, 8'h11, 1'b1);
    push_byte(0, 8'h12, 1'b1);
    push_byte(1, 8'h21, 1'b1);
    push_byte(2, 8'h31, 1'b1);
    push_byte(3, 8'h41, 1'b1);
    wait_idle("t2");
    chk("t2_frames", glog.size(), 5);
    for (int k = 0; k < 5; k++) chk("t2_order", glog[k], e2[k]);

    // Checksum wrap: 01+FF+FF+03 = 02
    slog.delete();
    push_byte(1, 8'hFF, 1'b0);
    push_byte(1, 8'hFF, 1'b0);
    push_byte(1, 8'h03, 1'b1);
    wait_idle("t3");
    chk("t3_len", slog.size(), 6);
    chk("t3_id", 32'(slog[1]), 32'h01);
    chk("t3_csum", 32'(slog[5]), 32'h02);

    // Granted requester withholds valid for 50 cycles mid-packet
    begin
      int ns;
      rdy_cnt[3] = 0;
      push_byte(3, 8'h01, 1'b0);
      push_byte(3, 8'h02, 1'b0);
      push_byte(3, 8'h03, 1'b0);
      push_byte(3, 8'h04, 1'b1);
      wait_ready("t4", 3, 2);
      step(1);
      hold[3] = 1'b1;
      ns = n_strobe;
      step(50);
      chk("t4_no_strobe_in_stall", n_strobe - ns, 0);
      hold[3] = 1'b0;
      wait_idle("t4");
      chk("t4_ready3_pulses", rdy_cnt[3], 4);
    end

    // Reset during DATA
    rdy_cnt[0] = 0;
    for (int b = 0; b < 6; b++) push_byte(0, 8'(8'h60 + b), b == 5);
    wait_ready("t5", 0, 1);
    step(1);
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      q_dat[i].delete();
      q_lst[i].delete();
    end
    @(negedge clk);
    @(negedge clk);
    chk("t5_grant_cleared", 32'(grant), 0);
    chk("t5_tx_start_low", 32'(tx_start), 0);
    chk("t5_fa_low", 32'(frame_active), 0);
    chk("t5_ready_low", 32'(req_ready), 0);
    step(1);
    rst = 1'b0;
    chk("t5_byte_in_flight", 32'(tx_busy), 1);
    slog.delete();
    push_byte(1, 8'h55, 1'b1);
    wait_idle("t5");
    chk("t5_len", slog.size(), 4);
    chk("t5_sof", 32'(slog[0]), 32'hA5);
    chk("t5_csum", 32'(slog[3]), 32'h56);

    // Transmitter busy for 100 cycles at grant
    begin
      int ns;
      force_busy = 1'b1;
      ns = n_strobe;
      push_byte(2, 8'h7E, 1'b1);
      step(100);
      chk("t6_no_strobe_while_busy", n_strobe - ns, 0);
      chk("t6_grant_held", 32'(grant), 32'h4);
      chk("t6_fa_held", 32'(frame_active), 1);
      force_busy = 1'b0;
      @(negedge clk);
      chk("t6_sof_first_free_cycle", 32'(tx_start), 1);
      chk("t6_sof_byte", 32'(tx_data), 32'hA5);
      wait_idle("t6");
    end

    // Random traffic, busy lengths and valid holds
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        int r;
        int len;
        r = $urandom_range(0, N - 1);
        if (q_dat[r].size() < 12) begin
          len = $urandom_range(1, 6);
          for (int b = 0; b < len; b++) push_byte(r, 8'($urandom_range(0, 255)), b == len - 1);
        end
      end
      if ($urandom_range(0, 99) == 0) busy_len = $urandom_range(1, 25);
      if ($urandom_range(0, 29) == 0) begin
        int h;
        h = $urandom_range(0, N - 1);
        hold[h] = ~hold[h];
      end
      step(1);
    end
    hold = '0;
    wait_idle("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
